alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 72 +++++++
 rtl/alu_pipe.sv | 155 +++++++++++++++
 tb/tb_alu_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag-bit positions and control-state encoding for alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_NOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_MUL    = 4'hC;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Signed byte add clamped to [-128, 127].
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, W iterations,
// done pulses for one cycle once product holds the full 2W-bit result.
module alu_mul_iter #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == CW'(W - 1)) begin
        cnt_d  = '0;
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with a one-entry registered output and ready/valid handshakes.
// Define ALU_PIPE_MUL_EN to add the iterative multiplier on opcode C.
module alu_pipe #(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] src0,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  import alu_pkg::*;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  state_t       state_q, state_d;
  logic [W-1:0] result_q, result_d;
  logic [2:0]   flags_q, flags_d;

  logic         busy, accept, is_mul, mul_done;
  logic [W-1:0] mul_res;
  logic [2:0]   mul_flg;
  logic [W-1:0] alu_res;
  logic [2:0]   alu_flg;
  logic [W-1:0] paddsb_res;
  logic [W:0]   add_ext, sub_ext;
  logic [W-1:0] add_sat, sub_sat;

  assign out_valid = (state_q == ST_DONE);
  assign in_ready  = !busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  logic [2*W-1:0] mul_product;
  logic           mul_start;

  assign mul_start = accept && is_mul;
  assign is_mul    = (op == OP_MUL);
  assign busy      = (state_q == ST_MUL_RUN);
  assign mul_res   = mul_product[W-1:0];
  assign mul_flg   = {mul_product[W-1], |mul_product[2*W-1:W], mul_product[W-1:0] == '0};

  alu_mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (src0),
    .b       (src1),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_flg  = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < W / 8; gi++) begin : g_byte
      assign paddsb_res[gi*8 +: 8] = sat_add8(src0[gi*8 +: 8], src1[gi*8 +: 8]);
    end
  endgenerate

  // One extra sign bit exposes overflow as a mismatch between the top two bits.
  assign add_ext = {src0[W-1], src0} + {src1[W-1], src1};
  assign sub_ext = {src0[W-1], src0} - {src1[W-1], src1};
  assign add_sat = (add_ext[W] != add_ext[W-1]) ? (add_ext[W] ? SMIN : SMAX) : add_ext[W-1:0];
  assign sub_sat = (sub_ext[W] != sub_ext[W-1]) ? (sub_ext[W] ? SMIN : SMAX) : sub_ext[W-1:0];

  always_comb begin
    alu_res = '0;
    alu_flg = flags_q;
    case (op)
      OP_ADD: begin
        alu_res = add_sat;
        alu_flg = {add_sat[W-1], add_ext[W] ^ add_ext[W-1], add_sat == '0};
      end
      OP_SUB: begin
        alu_res = sub_sat;
        alu_flg = {sub_sat[W-1], sub_ext[W] ^ sub_ext[W-1], sub_sat == '0};
      end
      OP_PADDSB: alu_res = paddsb_res;
      OP_AND:    alu_res = src0 & src1;
      OP_NOR:    alu_res = ~(src0 | src1);
      OP_SLL:    alu_res = src0 << src1[SHW-1:0];
      OP_SRL:    alu_res = src0 >> src1[SHW-1:0];
      OP_SRA:    alu_res = W'($signed(src0) >>> src1[SHW-1:0]);
      OP_LW,
      OP_SW:     alu_res = src0 + imm;
      OP_LHB:    alu_res = {imm[W/2-1:0], src0[W/2-1:0]};
      OP_LLB:    alu_res = imm;
      default:   alu_res = '0;
    endcase
    if (op inside {OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA})
      alu_flg[FLAG_Z] = (alu_res == '0);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = ST_MUL_RUN;
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            flags_d  = alu_flg;
          end
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_RUN: begin
        if (mul_done) begin
          state_d  = ST_DONE;
          result_d = mul_res;
          flags_d  = mul_flg;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized scoreboard bench for alu_pipe (W=16) with directed corner cases.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    op;
  logic [W-1:0]  src0, src1, imm, result;
  logic [2:0]    flags;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         ntx = 0;
  logic [2:0] model_flags = 3'b000;

  alu_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src0      (src0),
    .src1      (src1),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Behavioural model: signed integer arithmetic with explicit clamping.
  function automatic logic [18:0] ref_op(input logic [3:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] i,
                                         input logic [2:0] f);
    longint sa, sb, s, p;
    logic [15:0] r;
    logic [2:0]  nf;
    bit v;
    nf = f;
    r  = 16'h0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'h0, 4'h2: begin
        s = (o == 4'h0) ? sa + sb : sa - sb;
        v = 1'b0;
        if (s > 32767)  begin s = 32767;  v = 1'b1; end
        if (s < -32768) begin s = -32768; v = 1'b1; end
        r  = s[15:0];
        nf = {r[15], v, r == 16'h0};
      end
      4'h1: begin
        for (int k = 0; k < 2; k++) begin
          s = longint'($signed(a[k*8 +: 8])) + longint'($signed(b[k*8 +: 8]));
          if (s > 127)  s = 127;
          if (s < -128) s = -128;
          r[k*8 +: 8] = s[7:0];
        end
      end
      4'h3: begin r = a & b;        nf[0] = (r == 16'h0); end
      4'h4: begin r = ~(a | b);     nf[0] = (r == 16'h0); end
      4'h5: begin r = a << b[3:0];  nf[0] = (r == 16'h0); end
      4'h6: begin r = a >> b[3:0];  nf[0] = (r == 16'h0); end
      4'h7: begin s = sa >>> b[3:0]; r = s[15:0]; nf[0] = (r == 16'h0); end
      4'h8, 4'h9: r = a + i;
      4'hA: r = {i[7:0], a[7:0]};
      4'hB: r = i;
`ifdef ALU_PIPE_MUL_EN
      4'hC: begin
        p  = longint'(a) * longint'(b);
        r  = p[15:0];
        nf = {r[15], (p >> 16) != 0, r == 16'h0};
      end
`endif
      default: r = 16'h0;
    endcase
    return {nf, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request until accepted; the model result is queued on acceptance.
  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] i, input bit rnd, output int waits);
    bit acc;
    logic [18:0] r;
    acc   = 1'b0;
    waits = 0;
    op = o; src0 = a; src1 = b; imm = i;
    in_valid = 1'b1;
    while (!acc && waits < 200) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (!acc) waits++;
    end
    in_valid = 1'b0;
    if (acc) begin
      r = ref_op(o, a, b, i, model_flags);
      model_flags = r[18:16];
      exp_q.push_back('{op: o, res: r[15:0], flg: r[18:16]});
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout op=%h in_ready=%b required=1", o, in_ready);
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        e = exp_q.pop_front();
        ntx++;
        chk("result", 32'(result), 32'(e.res));
        chk("flags", 32'(flags), 32'(e.flg));
        $display("txn %0d op=%h result=%h flags=%b expected=%h/%b", ntx, e.op, result, flags, e.res, e.flg);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int w, late;
    logic [15:0] held;
    in_valid = 1'b0; op = 4'h0; src0 = '0; src1 = '0; imm = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    tick();

    out_ready = 1'b1;
    issue(OP_ADD, 16'h7FFF, 16'h0001, 16'h0, 1'b0, w);
    @(negedge clk);
    chk("add_latency", 32'(out_valid), 32'd1);
    chk("add_sat_result", 32'(result), 32'h7FFF);
    chk("add_sat_flags", 32'(flags), 32'b010);
    tick();

    issue(OP_SUB, 16'h0005, 16'h0005, 16'h0, 1'b0, w);
    @(negedge clk);
    chk("sub_zero_result", 32'(result), 32'h0);
    chk("sub_zero_flags", 32'(flags), 32'b001);
    tick();
    issue(OP_LLB, 16'hAAAA, 16'h5555, 16'h1234, 1'b0, w);
    @(negedge clk);
    chk("llb_result", 32'(result), 32'h1234);
    chk("llb_z_kept", 32'(flags[FLAG_Z]), 32'd1);
    tick();

    issue(OP_PADDSB, 16'h7F80, 16'h0180, 16'h0, 1'b0, w);
    @(negedge clk);
    chk("paddsb_result", 32'(result), 32'h7F80);
    chk("paddsb_flags_kept", 32'(flags), 32'b001);
    tick();

`ifdef ALU_PIPE_MUL_EN
    issue(OP_MUL, 16'h0100, 16'h0100, 16'h0, 1'b0, w);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) chk("mul_in_ready_low", 32'(in_ready), 32'd0);
      chk("mul_no_early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mul_valid_w_plus_1", 32'(out_valid), 32'd1);
    chk("mul_result", 32'(result), 32'h0);
    chk("mul_flags", 32'(flags), 32'b011);
    tick();
`else
    issue(OP_MUL, 16'h0100, 16'h0100, 16'h0, 1'b0, w);
    @(negedge clk);
    chk("opc_latency", 32'(out_valid), 32'd1);
    chk("opc_result", 32'(result), 32'h0);
    chk("opc_flags_kept", 32'(flags), 32'b001);
    tick();
`endif

    issue(OP_AND, 16'hF0F0, 16'h3C3C, 16'h0, 1'b0, w);
    out_ready = 1'b0;
    @(negedge clk);
    held = result;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'h3030);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    out_ready = 1'b1;
    issue(OP_ADD, 16'h0001, 16'h0002, 16'h0, 1'b0, w);
    chk("drain_accept_same_edge", 32'(w), 32'd0);
    @(negedge clk);
    chk("after_drain_accept", 32'(result), 32'h0003);
    chk("held_was_and", 32'(held), 32'h3030);
    tick();

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        tick();
      end
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), pick_operand(), 1'b1, w);
    end

    out_ready = 1'b1;
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    issue(OP_MUL, 16'h1234, 16'h5678, 16'h0, 1'b0, w);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    exp_q.delete();
    model_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    late = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    chk("no_late_result", 32'(late), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
